// File: rtl/seg_scan_display_pkg.sv
// Shared constants for the scrolling 7-segment display scanner.
// Provides blank patterns, digit count and the 16 active-low hex glyphs.
package seg_scan_display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIG_W      = $clog2(NUM_DIGITS);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Active-low {a,b,c,d,e,f,g}
    localparam logic [6:0] GLYPH_0 = 7'b0000001;
    localparam logic [6:0] GLYPH_1 = 7'b1001111;
    localparam logic [6:0] GLYPH_2 = 7'b0010010;
    localparam logic [6:0] GLYPH_3 = 7'b0000110;
    localparam logic [6:0] GLYPH_4 = 7'b1001100;
    localparam logic [6:0] GLYPH_5 = 7'b0100100;
    localparam logic [6:0] GLYPH_6 = 7'b0100000;
    localparam logic [6:0] GLYPH_7 = 7'b0001111;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0000100;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b1100000;
    localparam logic [6:0] GLYPH_C = 7'b0110001;
    localparam logic [6:0] GLYPH_D = 7'b1000010;
    localparam logic [6:0] GLYPH_E = 7'b0110000;
    localparam logic [6:0] GLYPH_F = 7'b0111000;

endpackage

// File: rtl/seg_scan_display_hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
// Ports: hex (4-bit value in), seg (7-bit {a..g} active-low out).
module hex_to_seg
    import seg_scan_display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (hex)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = GLYPH_A;
            4'hB: seg = GLYPH_B;
            4'hC: seg = GLYPH_C;
            4'hD: seg = GLYPH_D;
            4'hE: seg = GLYPH_E;
            4'hF: seg = GLYPH_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed 4-digit scroller: digit k shows pos + (3-k).
// Ports: clk, reset (sync, high), count_case in; an, seg, frame_tick out.
module seg_scan_display
    import seg_scan_display_pkg::*;
#(
    parameter int REFRESH_W    = 16,
    parameter int BLANK_CYCLES = 64
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] count_case,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame_tick
);

    localparam logic [REFRESH_W-1:0] SLOT_MAX = '1;
    localparam logic [REFRESH_W-1:0] BLANK_LIM =
        REFRESH_W'(BLANK_CYCLES);
    localparam logic [DIG_W-1:0] DIG_LAST =
        DIG_W'(NUM_DIGITS - 1);

    logic [REFRESH_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [DIG_W-1:0]     digit_sel_q, digit_sel_d;
    logic [3:0]           pos_q, pos_d;
    logic [3:0]           an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic                 tick_q, tick_d;

    logic                 slot_end;
    logic                 blank;
    logic [3:0]           glyph_idx;
    logic [6:0]           glyph_seg;

    // 3 - digit_sel equals ~digit_sel in two bits
    assign glyph_idx = pos_q + {2'b00, ~digit_sel_q};

    hex_to_seg u_hex_to_seg (
        .hex (glyph_idx),
        .seg (glyph_seg)
    );

    always_comb begin
        slot_end    = (slot_cnt_q == SLOT_MAX);
        blank       = (slot_cnt_q < BLANK_LIM);
        slot_cnt_d  = slot_cnt_q + REFRESH_W'(1);
        digit_sel_d = digit_sel_q;
        pos_d       = pos_q;
        tick_d      = 1'b0;
        if (slot_end) begin
            digit_sel_d = digit_sel_q - DIG_W'(1);
            // Latch only at frame end so a frame never tears
            if (digit_sel_q == '0) begin
                pos_d  = count_case;
                tick_d = 1'b1;
            end
        end
        // Cathodes are blanked with the anodes; the glyph
        // only changes while every digit is dark
        an_d  = blank ? AN_OFF : ~(4'b0001 << digit_sel_q);
        seg_d = blank ? SEG_BLANK : glyph_seg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt_q  <= '0;
            digit_sel_q <= DIG_LAST;
            pos_q       <= 4'h0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_BLANK;
            tick_q      <= 1'b0;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            digit_sel_q <= digit_sel_d;
            pos_q       <= pos_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            tick_q      <= tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = tick_q;

endmodule
